// File: rtl/task_packetizer.sv
// Frames the parser's flat word stream into NoC packets: address, size and service
// header flits, then the message words. Message length comes from the first two words.
module task_packetizer #(
    parameter int                   FLIT_SIZE = 32,
    parameter logic [FLIT_SIZE-1:0] SVC_DESCR = 32'h0000_0040,
    parameter logic [FLIT_SIZE-1:0] SVC_TASK  = 32'h0000_0041
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 src_tx_i,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    output logic                 src_credit_o,
    input  logic [15:0]          mapper_address_i,
    input  logic                 eoa_i,
    output logic                 noc_tx_o,
    output logic [FLIT_SIZE-1:0] noc_data_o,
    input  logic                 noc_credit_i,
    output logic                 busy_o,
    output logic                 eoa_o,
    output logic [15:0]          pkt_cnt_o
);

    typedef enum logic [3:0] {
        CAP0, CAP1, HDR_ADDR, HDR_SIZE, HDR_SVC, HOLD0, HOLD1, PASS, END
    } state_t;

    state_t               state, state_next;
    logic [FLIT_SIZE-1:0] hold0, hold1, remaining, size, size_calc, task_sum;
    logic [31:0]          tasks_left;
    logic                 is_task;
    logic                 src_xfer, noc_xfer;

    assign src_xfer = src_tx_i && src_credit_o;
    assign noc_xfer = noc_tx_o && noc_credit_i;
    assign busy_o   = (state != CAP0);

    // Size is computed while w1 is on the bus so it can be registered in CAP1.
    always_comb begin
        task_sum = hold0 + src_data_i;
        if (tasks_left != 32'd0)
            size_calc = FLIT_SIZE'(4) + (task_sum >> 2);
        else
            size_calc = FLIT_SIZE'(2) + (src_data_i << 1) + hold0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= CAP0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        src_credit_o = 1'b0;
        noc_tx_o     = 1'b0;
        noc_data_o   = '0;
        case (state)
            CAP0: begin
                src_credit_o = 1'b1;
                if (src_tx_i) state_next = CAP1;
            end
            CAP1: begin
                src_credit_o = 1'b1;
                if (src_tx_i) state_next = HDR_ADDR;
            end
            HDR_ADDR: begin
                noc_tx_o   = 1'b1;
                noc_data_o = FLIT_SIZE'(mapper_address_i);
                if (noc_credit_i) state_next = HDR_SIZE;
            end
            HDR_SIZE: begin
                noc_tx_o   = 1'b1;
                noc_data_o = size;
                if (noc_credit_i) state_next = HDR_SVC;
            end
            HDR_SVC: begin
                noc_tx_o   = 1'b1;
                noc_data_o = is_task ? SVC_TASK : SVC_DESCR;
                if (noc_credit_i) state_next = HOLD0;
            end
            HOLD0: begin
                noc_tx_o   = 1'b1;
                noc_data_o = hold0;
                if (noc_credit_i) state_next = HOLD1;
            end
            HOLD1: begin
                noc_tx_o   = 1'b1;
                noc_data_o = hold1;
                if (noc_credit_i) state_next = (remaining != '0) ? PASS : END;
            end
            PASS: begin
                noc_tx_o     = src_tx_i;
                noc_data_o   = src_data_i;
                src_credit_o = noc_credit_i;
                if (src_tx_i && noc_credit_i && remaining == FLIT_SIZE'(1))
                    state_next = END;
            end
            END: state_next = CAP0;
            default: state_next = CAP0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold0      <= '0;
            hold1      <= '0;
            size       <= '0;
            remaining  <= '0;
            is_task    <= 1'b0;
            tasks_left <= 32'd0;
            pkt_cnt_o  <= 16'd0;
            eoa_o      <= 1'b0;
        end else begin
            if (state == CAP0 && src_xfer)
                hold0 <= src_data_i;
            if (state == CAP1 && src_xfer) begin
                hold1     <= src_data_i;
                size      <= size_calc;
                remaining <= size_calc - FLIT_SIZE'(2);
                is_task   <= (tasks_left != 32'd0);
            end
            if (state == PASS && noc_xfer)
                remaining <= remaining - FLIT_SIZE'(1);
            if (state == END) begin
                pkt_cnt_o  <= pkt_cnt_o + 16'd1;
                // A descriptor's w1 is its task count.
                tasks_left <= is_task ? tasks_left - 32'd1 : 32'(hold1);
            end
            if (state == CAP0 && tasks_left == 32'd0 && eoa_i && !src_tx_i)
                eoa_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_task_packetizer.sv
// Directed bench for task_packetizer: table of packet vectors plus hand sequences
// for end-of-applications and asynchronous reset mid-packet.
module tb_task_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_tx = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_credit;
    logic [15:0] maddr = '0;
    logic        eoa_in = 1'b0;
    logic        noc_tx;
    logic [31:0] noc_data;
    logic        noc_credit = 1'b1;
    logic        busy;
    logic        eoa_out;
    logic [15:0] pkt_cnt;

    task_packetizer dut (
        .clk_i(clk), .rst_i(rst),
        .src_tx_i(src_tx), .src_data_i(src_data), .src_credit_o(src_credit),
        .mapper_address_i(maddr), .eoa_i(eoa_in),
        .noc_tx_o(noc_tx), .noc_data_o(noc_data), .noc_credit_i(noc_credit),
        .busy_o(busy), .eoa_o(eoa_out), .pkt_cnt_o(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          ws, nw, fs, nf;
        logic [15:0] pkt;
        int          busy_cyc;
        bit          stall;
    } vec_t;

    vec_t        vecs[$];
    vec_t        cur;
    logic [31:0] wq[$];
    logic [31:0] fq[$];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic open_vec(input logic [15:0] addr, input logic [15:0] pkt,
                            input int bc, input bit stall);
        cur.addr = addr; cur.pkt = pkt; cur.busy_cyc = bc; cur.stall = stall;
        cur.ws = wq.size(); cur.fs = fq.size();
    endtask

    task automatic close_vec();
        cur.nw = wq.size() - cur.ws;
        cur.nf = fq.size() - cur.fs;
        vecs.push_back(cur);
    endtask

    task automatic w(input logic [31:0] x); wq.push_back(x); endtask
    task automatic f(input logic [31:0] x); fq.push_back(x); endtask

    // Feeds one message, collects flits, returns once the block is back in CAP0
    // (or after stop_after flits when stop_after > 0).
    task automatic run_pkt(input int vi, input int stop_after);
        vec_t        v;
        int          wi, fi, bcyc, cyc;
        bit          seen, prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  pat;
        v = vecs[vi];
        wi = 0; fi = 0; bcyc = 0; seen = 0; prev_stall = 0; prev_data = '0;
        pat = 4'b1001;
        maddr = v.addr;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            noc_credit = v.stall ? pat[cyc % 4] : 1'b1;
            src_tx     = (wi < v.nw);
            src_data   = src_tx ? wq[v.ws + wi] : 32'd0;
            #1;
            if (busy) begin
                seen = 1;
                bcyc++;
            end else if (seen) begin
                break;
            end
            if (prev_stall) begin
                check($sformatf("v%0d stall tx", vi), {31'd0, noc_tx}, 32'd1);
                check($sformatf("v%0d stall data", vi), noc_data, prev_data);
            end
            if (noc_tx && !noc_credit)
                check($sformatf("v%0d stall src_credit", vi), {31'd0, src_credit}, 32'd0);
            prev_stall = noc_tx && !noc_credit;
            prev_data  = noc_data;
            if (noc_tx && noc_credit) begin
                if (fi < v.nf)
                    check($sformatf("v%0d flit%0d", vi, fi), noc_data, fq[v.fs + fi]);
                fi++;
            end
            if (src_tx && src_credit) wi++;
            if (stop_after > 0 && fi == stop_after) begin
                @(posedge clk);
                return;
            end
        end
        src_tx = 1'b0;
        check($sformatf("v%0d in time", vi), {31'd0, cyc < 300}, 32'd1);
        check($sformatf("v%0d flit count", vi), fi, v.nf);
        check($sformatf("v%0d pkt_cnt", vi), {16'd0, pkt_cnt}, {16'd0, v.pkt});
        if (v.busy_cyc > 0)
            check($sformatf("v%0d busy cycles", vi), bcyc, v.busy_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0: descriptor G=1 T=1
        open_vec(16'h0102, 16'd1, 10, 0);
        w(1); w(1); w(32'h0101); w(32'hFFFF_FFFF); w(7);
        f(32'h0102); f(5); f(32'h40); f(1); f(1); f(32'h0101); f(32'hFFFF_FFFF); f(7);
        close_vec();
        // 1: task text 8 data 4 -> 3 binary words
        open_vec(16'h0102, 16'd2, 12, 0);
        w(8); w(4); w(0); w(32'h80); w(32'hA); w(32'hB); w(32'hC);
        f(32'h0102); f(7); f(32'h41); f(8); f(4); f(0); f(32'h80); f(32'hA); f(32'hB); f(32'hC);
        close_vec();
        // 2: descriptor G=0 T=0, HOLD1 straight to END
        open_vec(16'h0102, 16'd3, 7, 0);
        w(0); w(0);
        f(32'h0102); f(2); f(32'h40); f(0); f(0);
        close_vec();
        // 3: descriptor again (T=0 before), stalled credit
        open_vec(16'h0A0B, 16'd4, 0, 1);
        w(2); w(0); w(32'hDEAD_0001); w(32'hDEAD_0002);
        f(32'h0A0B); f(4); f(32'h40); f(2); f(0); f(32'hDEAD_0001); f(32'hDEAD_0002);
        close_vec();
        // 4: descriptor G=0 T=1
        open_vec(16'h0A0B, 16'd5, 9, 0);
        w(0); w(1); w(32'h33); w(32'h44);
        f(32'h0A0B); f(4); f(32'h40); f(0); f(1); f(32'h33); f(32'h44);
        close_vec();
        // 5: task with zero text/data
        open_vec(16'h0A0B, 16'd6, 9, 0);
        w(0); w(0); w(32'h11); w(32'h22);
        f(32'h0A0B); f(4); f(32'h41); f(0); f(0); f(32'h11); f(32'h22);
        close_vec();
        // 6: descriptor G=0 T=1 ahead of the aborted task
        open_vec(16'h0304, 16'd7, 9, 0);
        w(0); w(1); w(32'hA); w(32'hB);
        f(32'h0304); f(4); f(32'h40); f(0); f(1); f(32'hA); f(32'hB);
        close_vec();
        // 7: task 16+16 -> 8 binary words, reset lands in PASS
        open_vec(16'h0304, 16'd0, 0, 0);
        w(32'h10); w(32'h10); w(0); w(32'h100);
        for (int i = 0; i < 8; i++) w(32'hB0 + i);
        f(32'h0304); f(12); f(32'h41); f(32'h10); f(32'h10); f(0); f(32'h100);
        for (int i = 0; i < 8; i++) f(32'hB0 + i);
        close_vec();
        // 8: descriptor after reset G=1 T=0
        open_vec(16'h0506, 16'd1, 8, 0);
        w(1); w(0); w(32'h55);
        f(32'h0506); f(3); f(32'h40); f(1); f(0); f(32'h55);
        close_vec();

        @(negedge clk); #1;
        check("reset src_credit", {31'd0, src_credit}, 32'd1);
        check("reset noc_tx", {31'd0, noc_tx}, 32'd0);
        check("reset noc_data", noc_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset eoa", {31'd0, eoa_out}, 32'd0);
        check("reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_pkt(i, 0);
        run_pkt(4, 0);

        // eoa_i while a task is still owed must not set eoa_o
        eoa_in = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("eoa held off", {31'd0, eoa_out}, 32'd0);
        end
        run_pkt(5, 0);
        check("eoa one-cycle delay", {31'd0, eoa_out}, 32'd0);
        @(negedge clk); #1;
        check("eoa set", {31'd0, eoa_out}, 32'd1);
        eoa_in = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            check("eoa sticky", {31'd0, eoa_out}, 32'd1);
        end

        run_pkt(6, 0);
        run_pkt(7, 7);
        @(negedge clk);
        src_tx   = 1'b1;
        src_data = 32'hB2;
        #1;
        check("pre-reset in PASS tx", {31'd0, noc_tx}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async rst noc_tx", {31'd0, noc_tx}, 32'd0);
        check("async rst noc_data", noc_data, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst src_credit", {31'd0, src_credit}, 32'd1);
        check("async rst pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        check("async rst eoa", {31'd0, eoa_out}, 32'd0);
        #1 rst = 1'b0;
        src_tx = 1'b0;
        run_pkt(8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
